alu_entry_controller: RTL and testbench

- Sequencing controller in front of the 4-bit board ALU.
- Captures operand A, operand B and the opcode one at a time from 4 slide switches, each on a debounced ENTER press. It then drives the ALU inputs, waits a fixed settle time, and latches the 8-bit result with valid and divide-by-zero flags for the display logic.
- Sits between board switches/buttons and the ALU/7-segment path.

---
 rtl/alu_entry_controller.sv | 207 ++++++++++++++++++++
 tb/tb_alu_entry_controller.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_entry_controller.sv
// Entry sequencer for the board ALU: collects A, B and opcode from the switches on
// debounced ENTER presses, waits for the ALU to settle, then latches the result.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_A    | waiting for ENTER to capture operand A from SW
// S_B    | waiting for ENTER to capture operand B from SW
// S_OP   | waiting for ENTER to capture opcode from SW[1:0]
// S_EXEC | ALU inputs driven, counting down the settle time
// S_SHOW | result latched and valid, ENTER returns to S_A
module alu_entry_controller #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int EXEC_WAIT       = 2
) (
    input  logic       CLK100MHZ,
    input  logic       RESET,
    input  logic [3:0] SW,
    input  logic       BTN_ENTER,
    input  logic       BTN_CLEAR,
    input  logic [7:0] alu_result,
    output logic [3:0] Num1,
    output logic [3:0] Num2,
    output logic [1:0] Op,
    output logic [7:0] result,
    output logic       result_valid,
    output logic       div_err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]       WAIT_LAST = 8'(EXEC_WAIT - 1);

    // Bit 0 is ENTER, bit 1 is CLEAR throughout the conditioning path.
    logic [1:0]       btn_raw;
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [1:0]       stable_q;
    logic [1:0]       stable_d;
    logic [1:0]       stable_prev_q;
    logic [CNT_W-1:0] db_cnt_q [2];
    logic [CNT_W-1:0] db_cnt_d [2];
    logic [1:0]       press;
    logic             enter_press;
    logic             clear_press;

    assign btn_raw = {BTN_CLEAR, BTN_ENTER};

    always_comb begin
        stable_d = stable_q;
        db_cnt_d = '{default: '0};
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (RESET) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            db_cnt_q      <= '{default: '0};
        end else begin
            sync1_q       <= btn_raw;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            db_cnt_q      <= db_cnt_d;
        end
    end

    assign press       = stable_q & ~stable_prev_q;
    assign enter_press = press[0];
    assign clear_press = press[1];

    // The state register is a plain vector so the unused codes 5..7 stay representable.
    logic [2:0] state_q;
    logic [2:0] state_d;
    logic [3:0] num1_q;
    logic [3:0] num1_d;
    logic [3:0] num2_q;
    logic [3:0] num2_d;
    logic [1:0] op_q;
    logic [1:0] op_d;
    logic [7:0] result_q;
    logic [7:0] result_d;
    logic       valid_q;
    logic       valid_d;
    logic       div_err_q;
    logic       div_err_d;
    logic [7:0] wait_q;
    logic [7:0] wait_d;

    always_comb begin
        state_d   = state_q;
        num1_d    = num1_q;
        num2_d    = num2_q;
        op_d      = op_q;
        result_d  = result_q;
        valid_d   = valid_q;
        div_err_d = div_err_q;
        wait_d    = wait_q;

        if (clear_press) begin
            state_d   = S_A;
            num1_d    = '0;
            num2_d    = '0;
            op_d      = '0;
            result_d  = '0;
            valid_d   = 1'b0;
            div_err_d = 1'b0;
            wait_d    = '0;
        end else begin
            case (state_q)
                S_A: begin
                    if (enter_press) begin
                        num1_d  = SW;
                        state_d = S_B;
                    end
                end
                S_B: begin
                    if (enter_press) begin
                        num2_d  = SW;
                        state_d = S_OP;
                    end
                end
                S_OP: begin
                    if (enter_press) begin
                        op_d    = SW[1:0];
                        wait_d  = WAIT_LAST;
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Terminal count: the ALU has had EXEC_WAIT cycles to settle.
                    if (wait_q == 8'd0) begin
                        if ((op_q == 2'b11) && (num2_q == 4'd0)) begin
                            result_d  = 8'h00;
                            div_err_d = 1'b1;
                        end else begin
                            result_d  = alu_result;
                            div_err_d = 1'b0;
                        end
                        valid_d = 1'b1;
                        state_d = S_SHOW;
                    end else begin
                        wait_d = wait_q - 8'd1;
                    end
                end
                S_SHOW: begin
                    if (enter_press) begin
                        valid_d   = 1'b0;
                        div_err_d = 1'b0;
                        state_d   = S_A;
                    end
                end
                default: state_d = S_A;
            endcase
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (RESET) begin
            state_q   <= S_A;
            num1_q    <= '0;
            num2_q    <= '0;
            op_q      <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            div_err_q <= 1'b0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            num1_q    <= num1_d;
            num2_q    <= num2_d;
            op_q      <= op_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            div_err_q <= div_err_d;
            wait_q    <= wait_d;
        end
    end

    assign Num1         = num1_q;
    assign Num2         = num2_q;
    assign Op           = op_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign div_err      = div_err_q;
    assign state        = state_q;

endmodule

// File: tb/tb_alu_entry_controller.sv
// Bench for alu_entry_controller: vector table, hand sequences for reset, bounce,
// clear and illegal state, and random operations against an arithmetic reference.
module tb_alu_entry_controller;

    logic       clk = 1'b0;
    logic       RESET;
    logic [3:0] SW;
    logic       BTN_ENTER;
    logic       BTN_CLEAR;
    logic [7:0] alu_result;
    logic [3:0] Num1;
    logic [3:0] Num2;
    logic [1:0] Op;
    logic [7:0] result;
    logic       result_valid;
    logic       div_err;
    logic [2:0] state;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_entry_controller #(
        .DEBOUNCE_CYCLES(4),
        .EXEC_WAIT      (2)
    ) dut (
        .CLK100MHZ   (clk),
        .RESET       (RESET),
        .SW          (SW),
        .BTN_ENTER   (BTN_ENTER),
        .BTN_CLEAR   (BTN_CLEAR),
        .alu_result  (alu_result),
        .Num1        (Num1),
        .Num2        (Num2),
        .Op          (Op),
        .result      (result),
        .result_valid(result_valid),
        .div_err     (div_err),
        .state       (state)
    );

    // Board ALU stand-in; divide by zero returns FF so the controller's override is visible.
    function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        case (op)
            2'd0:    return 8'(a) + 8'(b);
            2'd1:    return (a >= b) ? 8'(a - b) : 8'(b - a);
            2'd2:    return 8'(a) * 8'(b);
            default: return (b == 4'd0) ? 8'hFF : 8'(a / b);
        endcase
    endfunction

    always_comb alu_result = alu_fn(Num1, Num2, Op);

    // Expected {div_err, result} straight from the operation definitions.
    function automatic logic [8:0] ref_op(input int a, input int b, input int op);
        int r;
        r = 0;
        if (op == 0) r = a + b;
        else if (op == 1) r = (a > b) ? a - b : b - a;
        else if (op == 2) r = a * b;
        else if (b == 0) return {1'b1, 8'h00};
        else r = a / b;
        return {1'b0, 8'(r)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic press_enter(input logic [3:0] sw);
        @(negedge clk);
        SW        = sw;
        BTN_ENTER = 1'b1;
        repeat (10) @(negedge clk);
        BTN_ENTER = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic press_clear();
        @(negedge clk);
        BTN_CLEAR = 1'b1;
        repeat (10) @(negedge clk);
        BTN_CLEAR = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    // Opcode press with per-cycle observation; optional enter injection in EXEC or
    // a CLEAR raw edge one cycle behind ENTER so its press lands in the first EXEC cycle.
    task automatic press_op_watch(input logic [3:0] sw, input bit inject_enter, input bit with_clear,
                                  output int exec_cycles, output int first_exec, output int first_valid);
        bit forced;
        forced      = 1'b0;
        exec_cycles = 0;
        first_exec  = -1;
        first_valid = -1;
        @(negedge clk);
        SW        = sw;
        BTN_ENTER = 1'b1;
        if (with_clear) begin
            @(negedge clk);
            BTN_CLEAR = 1'b1;
        end
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (forced) begin
                release dut.enter_press;
                forced = 1'b0;
            end
            if (state == 3'd3) begin
                exec_cycles++;
                if (first_exec < 0) begin
                    first_exec = i;
                    if (inject_enter) begin
                        force dut.enter_press = 1'b1;
                        forced = 1'b1;
                    end
                end
            end
            if (result_valid && first_valid < 0) first_valid = i;
            if (i == 10) begin
                BTN_ENTER = 1'b0;
                BTN_CLEAR = 1'b0;
            end
        end
    endtask

    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op,
                          input logic [7:0] er, input logic ee, input bit inject);
        int ec, fe, fv;
        press_enter(a);
        chk("state_after_a", 32'(state), 32'd1);
        chk("num1_latched", 32'(Num1), 32'(a));
        press_enter(b);
        chk("state_after_b", 32'(state), 32'd2);
        chk("num2_latched", 32'(Num2), 32'(b));
        press_op_watch(4'(op) | 4'b1100, inject, 1'b0, ec, fe, fv);
        chk("exec_cycles", 32'(ec), 32'd2);
        chk("valid_delay", 32'(fv - fe), 32'd2);
        chk("state_show", 32'(state), 32'd4);
        chk("op_latched", 32'(Op), 32'(op));
        chk("result", 32'(result), 32'(er));
        chk("result_valid", 32'(result_valid), 32'd1);
        chk("div_err", 32'(div_err), 32'(ee));
        press_enter(4'hF);
        chk("state_back_a", 32'(state), 32'd0);
        chk("valid_cleared", 32'(result_valid), 32'd0);
        chk("div_err_cleared", 32'(div_err), 32'd0);
        chk("num1_retained", 32'(Num1), 32'(a));
        chk("result_retained", 32'(result), 32'(er));
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
        logic [7:0] exp_res;
        logic       exp_err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ec, fe, fv;
        logic [3:0] ra, rb;
        logic [1:0] rop;
        logic [8:0] rexp;

        vecs[0] = '{4'd7,  4'd6,  2'd2, 8'd42,  1'b0};
        vecs[1] = '{4'd9,  4'd0,  2'd3, 8'd0,   1'b1};
        vecs[2] = '{4'd15, 4'd15, 2'd2, 8'd225, 1'b0};
        vecs[3] = '{4'd15, 4'd15, 2'd0, 8'd30,  1'b0};
        vecs[4] = '{4'd12, 4'd5,  2'd3, 8'd2,   1'b0};
        vecs[5] = '{4'd0,  4'd0,  2'd3, 8'd0,   1'b1};
        vecs[6] = '{4'd2,  4'd11, 2'd1, 8'd9,   1'b0};
        vecs[7] = '{4'd3,  4'd9,  2'd1, 8'd6,   1'b0};

        RESET     = 1'b1;
        SW        = 4'd5;
        BTN_ENTER = 1'b0;
        BTN_CLEAR = 1'b0;

        // Reset with buttons toggling.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            BTN_ENTER = (i != 1);
            BTN_CLEAR = (i != 0);
        end
        @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_outputs", 32'({Num1, Num2, Op, result, result_valid, div_err}), 32'd0);
        RESET     = 1'b0;
        BTN_ENTER = 1'b0;
        BTN_CLEAR = 1'b0;
        repeat (12) @(negedge clk);
        chk("rst_no_press_state", 32'(state), 32'd0);
        chk("rst_no_press_num1", 32'(Num1), 32'd0);

        // ENTER held through reset release gives exactly one press.
        RESET     = 1'b1;
        SW        = 4'd3;
        BTN_ENTER = 1'b1;
        repeat (3) @(negedge clk);
        RESET = 1'b0;
        repeat (15) @(negedge clk);
        chk("held_press_state", 32'(state), 32'd1);
        chk("held_press_num1", 32'(Num1), 32'd3);
        BTN_ENTER = 1'b0;
        repeat (12) @(negedge clk);
        chk("held_single_press", 32'(state), 32'd1);
        press_clear();
        chk("clear_state", 32'(state), 32'd0);
        chk("clear_num1", 32'(Num1), 32'd0);

        // Bouncing ENTER, then a clean hold.
        SW = 4'd9;
        for (int i = 0; i < 10; i++) begin
            BTN_ENTER = ~BTN_ENTER;
            repeat (2) @(negedge clk);
        end
        chk("bounce_no_press", 32'(state), 32'd0);
        BTN_ENTER = 1'b1;
        repeat (15) @(negedge clk);
        chk("bounce_state", 32'(state), 32'd1);
        chk("bounce_num1", 32'(Num1), 32'd9);
        BTN_ENTER = 1'b0;
        repeat (12) @(negedge clk);
        chk("bounce_single_press", 32'(state), 32'd1);

        // Simultaneous ENTER and CLEAR in S_B.
        @(negedge clk);
        SW        = 4'd5;
        BTN_ENTER = 1'b1;
        BTN_CLEAR = 1'b1;
        repeat (10) @(negedge clk);
        BTN_ENTER = 1'b0;
        BTN_CLEAR = 1'b0;
        repeat (10) @(negedge clk);
        chk("both_state", 32'(state), 32'd0);
        chk("both_num2", 32'(Num2), 32'd0);
        chk("both_num1", 32'(Num1), 32'd0);

        // Illegal state code recovers to S_A.
        @(negedge clk);
        force dut.state_q = 3'd6;
        @(posedge clk);
        #1;
        release dut.state_q;
        @(negedge clk);
        @(negedge clk);
        chk("illegal_state_recover", 32'(state), 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp_res, vecs[i].exp_err, i == 2);
        end

        // CLEAR landing in S_EXEC aborts with nothing latched.
        press_enter(4'd4);
        press_enter(4'd3);
        press_op_watch(4'd2, 1'b0, 1'b1, ec, fe, fv);
        chk("clr_exec_seen", 32'(fe >= 0), 32'd1);
        chk("clr_exec_short", 32'(ec), 32'd1);
        chk("clr_no_valid", 32'(fv), 32'hFFFF_FFFF);
        chk("clr_state", 32'(state), 32'd0);
        chk("clr_regs", 32'({Num1, Num2, Op}), 32'd0);
        chk("clr_result", 32'(result), 32'd0);
        chk("clr_flags", 32'({result_valid, div_err}), 32'd0);

        for (int i = 0; i < 30; i++) begin
            ra  = 4'($urandom_range(0, 15));
            rb  = (i % 5 == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            rop = 2'($urandom_range(0, 3));
            rexp = ref_op(int'(ra), int'(rb), int'(rop));
            run_op(ra, rb, rop, rexp[7:0], rexp[8], 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
